uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ byte-stream requesters using round-robin arbitration.
- Accepts one byte per valid/ready handshake, launches it with a single-cycle TX_START pulse, holds TX_DATA stable until TX_DONE, then arbitrates again.
- A packet-lock (REQ_LAST) keeps multi-byte messages contiguous on the wire.
- A watchdog recovers if TX_DONE never arrives.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, byte width; must match the serializer (5..9).
- TIMEOUT_CLKS, 1024, maximum cycles to wait for TX_DONE; must exceed CLKS_PER_BIT*(DATA_WIDTH+2).

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RSTN  in  1  asynchronous, active-low reset.
- REQ_VALID  in  NUM_REQ  per-requester byte valid.
- REQ_DATA  in  NUM_REQ*DATA_WIDTH  requester i byte at [i*DATA_WIDTH +: DATA_WIDTH].
- REQ_LAST  in  NUM_REQ  byte is the final byte of its packet.
- REQ_READY  out  NUM_REQ  one-hot accept; at most one bit set.
- TX_START  out  1  one-cycle launch pulse to the serializer.
- TX_DATA  out  DATA_WIDTH  byte to serialize; stable from TX_START until TX_DONE.
- TX_DONE  in  1  one-cycle frame-complete pulse from the serializer.
- GRANT  out  NUM_REQ  one-hot owner of the current or last byte.
- BUSY  out  1  high when the state is not IDLE.
- TIMEOUT_ERR  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; TX_START=0, TX_DATA=0, GRANT=0, TIMEOUT_ERR=0.
  - lock=0, rr_ptr=NUM_REQ-1, wdog=0.
- States: IDLE, WAIT_DONE.
- IDLE:
  - Eligible set = REQ_VALID when lock=0; only REQ_VALID[lock_id] when lock=1.
  - Winner = first eligible index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - REQ_READY[winner] is asserted combinationally in IDLE only; 0 in every other state.
- Handshake (REQ_VALID[w] & REQ_READY[w]), all registered on the same edge:
  - TX_DATA <= REQ_DATA[w]; TX_START <= 1; GRANT <= onehot(w); wdog <= 0; state <= WAIT_DONE.
  - If REQ_LAST[w]=0: lock <= 1, lock_id <= w. Otherwise lock <= 0.
  - rr_ptr <= w, updated only when REQ_LAST[w]=1, so a locked packet does not advance fairness.
- WAIT_DONE:
  - TX_START <= 0, giving exactly one cycle high; wdog increments each cycle.
  - TX_DONE=1 -> state <= IDLE; the next byte can handshake on the following cycle, giving a 1-cycle idle gap between frames.
  - wdog = TIMEOUT_CLKS-1 without TX_DONE -> TIMEOUT_ERR pulses 1 cycle, lock <= 0, state <= IDLE.
  - TX_DONE and timeout on the same cycle -> TX_DONE wins and no error is raised.
- TX_DONE while in IDLE is ignored.
- Requesters must hold REQ_VALID/REQ_DATA/REQ_LAST stable until accepted. A requester that drops VALID while locked stalls all others until it returns or a reset occurs; this is deliberate.
- Latency: handshake edge -> TX_START high next cycle. TX_START cannot be reasserted before TX_DONE.
- Reset mid-frame: all outputs return to reset values immediately, the packet lock is cleared, and no byte is replayed. The serializer shares RSTN and returns to idle.

Test Plan:
1. Requester 2 sends 0xA5 with LAST=1, TX_DONE returned 870 cycles after TX_START -> REQ_READY=0100 for one cycle, TX_START one pulse, TX_DATA=0xA5 stable through TX_DONE, BUSY high throughout, GRANT=0100.
2. Requesters 0, 1 and 3 all valid with LAST=1 from reset -> accepted order 0, 1, 3, then 0 again if 0 is still valid; no requester is skipped or repeated.
3. Requester 1 sends 3-byte packet 0x11/0x22/0x33 (LAST on 0x33) while requester 0 is continuously valid -> the wire order is 0x11, 0x22, 0x33 before any requester 0 byte; rr_ptr=1 afterwards, so requester 0 is served next.
4. TX_DONE is never returned -> TIMEOUT_ERR pulses exactly TIMEOUT_CLKS cycles after TX_START, state returns to IDLE, lock clears, and the next valid requester is accepted.
5. TX_DONE coincides with wdog = TIMEOUT_CLKS-1 -> no TIMEOUT_ERR, normal return to IDLE.
6. RSTN asserted mid-frame with lock=1 -> all outputs reach reset values without a clock edge; after release a different requester can win immediately.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ byte streams,
// with packet lock (REQ_LAST) and a TX_DONE watchdog.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned TIMEOUT_CLKS = 1024
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_LAST,
  output logic [NUM_REQ-1:0]            REQ_READY,
  output logic                          TX_START,
  output logic [DATA_WIDTH-1:0]         TX_DATA,
  input  logic                          TX_DONE,
  output logic [NUM_REQ-1:0]            GRANT,
  output logic                          BUSY,
  output logic                          TIMEOUT_ERR
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CLKS) + 1;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DONE = 1'b1
  } state_t;

  state_t              state;
  logic                lock;
  logic [IDX_W-1:0]    lock_id;
  logic [IDX_W-1:0]    rr_ptr;
  logic [WDOG_W-1:0]   wdog;

  logic [NUM_REQ-1:0]    eligible;
  logic                  found;
  logic [IDX_W-1:0]      winner;
  logic [IDX_W-1:0]      cand;
  logic [DATA_WIDTH-1:0] win_data;

  // A locked packet owner is the only candidate until its last byte goes out
  always_comb begin
    eligible = lock ? (REQ_VALID & (NUM_REQ'(1) << lock_id)) : REQ_VALID;
  end

  // First eligible requester after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) win_data = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign REQ_READY = (state == IDLE && found) ? (NUM_REQ'(1) << winner) : '0;
  assign BUSY      = (state == WAIT_DONE);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= IDLE;
      TX_START    <= 1'b0;
      TX_DATA     <= '0;
      GRANT       <= '0;
      TIMEOUT_ERR <= 1'b0;
      lock        <= 1'b0;
      lock_id     <= '0;
      rr_ptr      <= IDX_W'(NUM_REQ - 1);
      wdog        <= '0;
    end else begin
      TX_START    <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            TX_DATA  <= win_data;
            TX_START <= 1'b1;
            GRANT    <= NUM_REQ'(1) << winner;
            wdog     <= '0;
            state    <= WAIT_DONE;
            // Fairness pointer only moves once a whole packet has been sent
            if (REQ_LAST[winner]) begin
              lock   <= 1'b0;
              rr_ptr <= winner;
            end else begin
              lock    <= 1'b1;
              lock_id <= winner;
            end
          end
        end
        WAIT_DONE: begin
          wdog <= wdog + WDOG_W'(1);
          if (TX_DONE) begin
            state <= IDLE;
          end else if (wdog == WDOG_W'(TIMEOUT_CLKS - 1)) begin
            TIMEOUT_ERR <= 1'b1;
            lock        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
